mux_nx1_skid: RTL and testbench

//   Parametrised N:1 word multiplexer with a registered, valid/ready-handshaked output
//   and a 2-entry skid buffer. Successor to the fixed 5-bit 2:1 select used in the

---
 rtl/mux_nx1_skid.sv | 111 +++++++++++
 tb/tb_mux_nx1_skid.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_nx1_skid.sv
// N:1 word multiplexer with a registered valid/ready output and a 2-entry skid buffer.
// Ready is a registered occupancy decode, so there is no combinational ready-to-ready path.
module mux_nx1_skid #(
  parameter int unsigned WIDTH  = 5,
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic [WIDTH*NUM_IN-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] skid_q;
  logic [WIDTH-1:0] main_d, skid_d;
  logic [WIDTH-1:0] sel_word;
  logic             sel_hit;
  logic             accept, emit;
  logic             err_d, ready_d, valid_d;

  // Select decode; an out-of-range index yields zero and no hit.
  always_comb begin
    sel_word = '0;
    sel_hit  = 1'b0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (in_sel == SEL_W'(k)) begin
        sel_word = in_data[k*WIDTH +: WIDTH];
        sel_hit  = 1'b1;
      end
    end
  end

  // Occupancy next-state and storage updates.
  always_comb begin
    state_d = state_q;
    main_d  = out_data;
    skid_d  = skid_q;
    accept  = in_valid & in_ready;
    emit    = out_valid & out_ready;
    err_d   = sel_err | (accept & ~sel_hit);

    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = ONE;
          main_d  = sel_word;
        end
      end
      ONE: begin
        if (accept && emit) begin
          main_d = sel_word;
        end else if (accept) begin
          state_d = FULL;
          skid_d  = sel_word;
        end else if (emit) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (emit) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase

    // Flush drops everything held and the word offered this cycle.
    if (flush) begin
      state_d = EMPTY;
      main_d  = out_data;
      skid_d  = skid_q;
    end

    ready_d = (state_d != FULL);
    valid_d = (state_d != EMPTY);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= EMPTY;
      out_data  <= '0;
      skid_q    <= '0;
      sel_err   <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_data  <= main_d;
      skid_q    <= skid_d;
      sel_err   <= err_d;
      in_ready  <= ready_d;
      out_valid <= valid_d;
    end
  end

endmodule

// File: tb/tb_mux_nx1_skid.sv
// Bench for mux_nx1_skid: directed cases plus random back-pressure against a queue scoreboard.
module tb_mux_nx1_skid;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready, sel_err;
  logic [19:0] in_data;
  logic [1:0]  in_sel;
  logic [4:0]  out_data;

  logic        d5_flush, d5_valid, d5_in_ready, d5_out_valid, d5_out_ready, d5_sel_err;
  logic [24:0] d5_data;
  logic [2:0]  d5_sel;
  logic [4:0]  d5_out_data;

  int errors = 0;
  int checks = 0;
  int pops   = 0;
  logic [4:0] q[$];
  logic       armed = 1'b0;
  logic       stall_prev = 1'b0;
  logic [4:0] held = '0;

  localparam logic [19:0] D = {5'd31, 5'd17, 5'd9, 5'd3};

  always #5 clk = ~clk;

  mux_nx1_skid #(.WIDTH(5), .NUM_IN(4), .SEL_W(2)) u_dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .sel_err(sel_err)
  );

  mux_nx1_skid #(.WIDTH(5), .NUM_IN(5), .SEL_W(3)) u_dut5 (
    .clk(clk), .reset(reset), .flush(d5_flush),
    .in_data(d5_data), .in_sel(d5_sel), .in_valid(d5_valid), .in_ready(d5_in_ready),
    .out_data(d5_out_data), .out_valid(d5_out_valid), .out_ready(d5_out_ready),
    .sel_err(d5_sel_err)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] pick(input logic [19:0] d, input int s);
    logic [19:0] sh;
    if (s >= 4) return 5'd0;
    sh = d >> (s * 5);
    return sh[4:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [19:0] d, input logic [1:0] s);
    logic acc;
    int   n;
    in_data  = d;
    in_sel   = s;
    in_valid = 1'b1;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 1000) begin
      acc = in_ready;
      tick();
      n++;
    end
    in_valid = 1'b0;
    if (!acc) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    n = 0;
    while ((out_valid || q.size() != 0) && n < 1000) begin
      tick();
      n++;
    end
    check("drain_valid", 32'(out_valid), 32'd0);
  endtask

  // Scoreboard: transfers are decided by the values stable at the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      armed      = 1'b1;
      stall_prev = 1'b0;
    end else if (armed) begin
      check("in_ready", 32'(in_ready), 32'(q.size() < 2));
      check("out_valid", 32'(out_valid), 32'(q.size() != 0));
      if (stall_prev) check("stall_stable", 32'(out_data), 32'(held));
      if (out_valid && out_ready && q.size() != 0) begin
        check("data", 32'(out_data), 32'(q.pop_front()));
        pops++;
      end
      stall_prev = out_valid && !out_ready && !flush;
      held       = out_data;
      if (flush) q.delete();
      else if (in_valid && in_ready) q.push_back(pick(in_data, int'(in_sel)));
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   p0, sent, cyc;
    logic acc;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_sel = '0; out_ready = 1'b0;
    d5_flush = 1'b0; d5_valid = 1'b0; d5_data = '0; d5_sel = '0; d5_out_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_sel_err", 32'(sel_err), 32'd0);

    // Single word, latency one.
    out_ready = 1'b1;
    send(D, 2'd2);
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_data", 32'(out_data), 32'd17);
    tick();
    check("t1_gone", 32'(out_valid), 32'd0);

    // Fill under back-pressure, then release and keep streaming.
    out_ready = 1'b0;
    p0 = pops;
    send(D, 2'd0);
    send(D, 2'd1);
    check("t2_full_ready", 32'(in_ready), 32'd0);
    check("t2_head", 32'(out_data), 32'd3);
    out_ready = 1'b1;
    send(D, 2'd2);
    send(D, 2'd3);
    drain();
    check("t2_count", 32'(pops - p0), 32'd4);

    // Range boundary on the 5-input instance; sel_err survives flush.
    d5_data  = {5'd21, 5'd13, 5'd7, 5'd5, 5'd2};
    d5_sel   = 3'd4;
    d5_valid = 1'b1;
    tick();
    check("t3_in4_data", 32'(d5_out_data), 32'd21);
    check("t3_in4_err", 32'(d5_sel_err), 32'd0);
    d5_sel = 3'd5;
    tick();
    d5_valid = 1'b0;
    check("t3_oor_data", 32'(d5_out_data), 32'd0);
    check("t3_oor_valid", 32'(d5_out_valid), 32'd1);
    check("t3_oor_err", 32'(d5_sel_err), 32'd1);
    d5_flush = 1'b1;
    tick();
    d5_flush = 1'b0;
    check("t3_flush_err", 32'(d5_sel_err), 32'd1);
    check("t3_flush_valid", 32'(d5_out_valid), 32'd0);
    check("t3_flush_ready", 32'(d5_in_ready), 32'd1);

    // Flush from FULL, then a fresh word with latency one.
    out_ready = 1'b0;
    send(D, 2'd3);
    send(D, 2'd0);
    check("t4_full", 32'(in_ready), 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t4_valid", 32'(out_valid), 32'd0);
    check("t4_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    send(D, 2'd1);
    check("t4_lat_valid", 32'(out_valid), 32'd1);
    check("t4_lat_data", 32'(out_data), 32'd9);
    drain();

    // Reset while holding one word.
    out_ready = 1'b0;
    send(D, 2'd3);
    check("t5_pre_valid", 32'(out_valid), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_valid", 32'(out_valid), 32'd0);
    check("t5_data", 32'(out_data), 32'd0);
    check("t5_ready", 32'(in_ready), 32'd1);
    check("t5_sel_err", 32'(sel_err), 32'd0);
    check("t5_d5_sel_err", 32'(d5_sel_err), 32'd0);
    check("t5_d5_data", 32'(d5_out_data), 32'd0);

    // Random valid/ready traffic.
    sent = 0;
    cyc  = 0;
    while (sent < 10000 && cyc < 60000) begin
      if (!in_valid && $urandom_range(0, 9) < 6) begin
        in_data  = 20'($urandom);
        in_sel   = 2'($urandom_range(0, 3));
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(0, 9) < 7);
      acc = in_valid && in_ready;
      tick();
      cyc++;
      if (acc) begin
        sent++;
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check("rand_sent", 32'(sent), 32'd10000);
    drain();
    check("final_sel_err", 32'(sel_err), 32'd0);

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
